// File: rtl/program_loader_pkg.sv
// Shared widths, loader FSM encoding and state decode helpers.
// The CHECK state exists only when LOADER_CHECKSUM_EN is defined.
package program_loader_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  function automatic logic accepts_bytes(state_t s);
    logic r;
    r = 1'b0;
    case (s)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: r = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // The CPU runs only while the loader is parked; everything else is a load.
  function automatic logic holds_cpu(state_t s);
    return !(s inside {S_IDLE, S_DONE, S_ERR});
  endfunction

endpackage

// File: rtl/loader_addr_counter.sv
// Word index counter for the program loader: synchronous clear and increment.
module loader_addr_counter
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inc,
  output logic [WORD_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc)
      count <= count + WORD_W'(1);
  end

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader writing 16-bit words into instruction RAM.
// Optional trailer checksum enabled by defining LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [WORD_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_data,
  output logic              wr_enable,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_FRAME = S_CHECK;
  logic [BYTE_W-1:0] csum;
`else
  localparam state_t AFTER_FRAME = S_DONE;
  assign err = 1'b0;
`endif

  state_t            state, nxt;
  logic [WORD_W-1:0] len;
  logic [BYTE_W-1:0] hi_byte;
  logic [WORD_W-1:0] index;
  logic              fire, launch, last_word, len_zero;

  assign fire      = byte_valid && byte_ready;
  assign launch    = start && !holds_cpu(state);
  assign last_word = (index == len - WORD_W'(1));
  assign len_zero  = ({len[WORD_W-1:BYTE_W], byte_in} == '0);

  loader_addr_counter u_index (
    .clk   (clk),
    .rst   (rst),
    .clear (launch),
    .inc   (state == S_WRITE),
    .count (index)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) nxt = S_LEN_HI;
      S_LEN_HI:  if (fire) nxt = S_LEN_LO;
      S_LEN_LO:  if (fire) nxt = len_zero ? AFTER_FRAME : S_DATA_HI;
      S_DATA_HI: if (fire) nxt = S_DATA_LO;
      S_DATA_LO: if (fire) nxt = S_WRITE;
      S_WRITE:   nxt = last_word ? AFTER_FRAME : S_DATA_HI;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:   if (fire) nxt = ((byte_in ^ csum) == '0) ? S_DONE : S_ERR;
`endif
      default:   nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      len        <= '0;
      hi_byte    <= '0;
      byte_ready <= 1'b0;
      wr_enable  <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
      err        <= 1'b0;
`endif
    end else begin
      state      <= nxt;
      byte_ready <= accepts_bytes(nxt);
      cpu_hold   <= holds_cpu(nxt);
      done       <= (nxt == S_DONE);
      wr_enable  <= (nxt == S_WRITE);
      if (fire && state == S_LEN_HI)  len[WORD_W-1:BYTE_W] <= byte_in;
      if (fire && state == S_LEN_LO)  len[BYTE_W-1:0] <= byte_in;
      if (fire && state == S_DATA_HI) hi_byte <= byte_in;
      if (fire && state == S_DATA_LO) begin
        ram_addr <= index;
        ram_data <= {hi_byte, byte_in};
      end
`ifdef LOADER_CHECKSUM_EN
      err <= (nxt == S_ERR);
      // The trailer itself is compared against, never folded in.
      if (launch)
        csum <= '0;
      else if (fire && state != S_CHECK)
        csum <= csum ^ byte_in;
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader; handles builds with and without
// LOADER_CHECKSUM_EN (trailer byte computed by the reference model).
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready, wr_enable, cpu_hold, done, err;
  logic [15:0] ram_addr, ram_data;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] wr_q[$];
  logic [15:0] frame_words[$];

  typedef struct {
    int               n;
    logic [2:0][15:0] w;
    int               exp_writes;
    logic [31:0]      exp_last;
  } frame_vec_t;

  frame_vec_t tbl[4];

  always #5 clk = ~clk;

  program_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .wr_enable  (wr_enable),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Every write strobe is logged; the loader must not take bytes while writing.
  always @(negedge clk) begin
    if (wr_enable === 1'b1) begin
      wr_q.push_back({ram_addr, ram_data});
      checkOutput("ready_low_in_write", 32'(byte_ready), 32'd0);
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input bit rnd);
    bit acc = 1'b0;
    int guard = 0;
    while (!acc) begin
      byte_in    = b;
      byte_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      acc = byte_valid && byte_ready;
      @(posedge clk); #1;
      guard++;
      if (!acc && guard >= 100) begin
        checks++;
        errors++;
        $display("[TB] FAIL byte_accept_timeout: byte %02h not taken, byte_ready=%0b expected 1",
                 b, byte_ready);
        break;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic startLoad();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_zero_outputs(input string name);
    checkOutput({name, "_byte_ready"}, 32'(byte_ready), 32'd0);
    checkOutput({name, "_wr_enable"},  32'(wr_enable),  32'd0);
    checkOutput({name, "_cpu_hold"},   32'(cpu_hold),   32'd0);
    checkOutput({name, "_done"},       32'(done),       32'd0);
    checkOutput({name, "_err"},        32'(err),        32'd0);
    checkOutput({name, "_ram_addr"},   32'(ram_addr),   32'd0);
    checkOutput({name, "_ram_data"},   32'(ram_data),   32'd0);
  endtask

  // Reference model: frame bytes and expected writes come from frame_words.
  task automatic load_frame(input bit rnd, input bit corrupt);
    logic [7:0]  sum = 8'h00;
    int          n = frame_words.size();
    logic [15:0] nw = 16'(n);
    logic [15:0] w;
    wr_q.delete();
    startLoad();
    checkOutput("hold_during_load", 32'(cpu_hold), 32'd1);
    applyStimulus(nw[15:8], rnd); sum ^= nw[15:8];
    applyStimulus(nw[7:0], rnd);  sum ^= nw[7:0];
    for (int i = 0; i < n; i++) begin
      w = frame_words[i];
      applyStimulus(w[15:8], rnd); sum ^= w[15:8];
      applyStimulus(w[7:0], rnd);  sum ^= w[7:0];
      checkOutput("write_strobe_timing", 32'(wr_enable), 32'd1);
      checkOutput("write_addr_timing", 32'(ram_addr), 32'(i));
    end
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(sum ^ (corrupt ? 8'h01 : 8'h00), rnd);
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("write_count", 32'(wr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_q.size(); i++)
      checkOutput("write_word", wr_q[i], {16'(i), frame_words[i]});
    checkOutput("frame_done", 32'(done), 32'(!corrupt));
    checkOutput("frame_err", 32'(err), 32'(corrupt));
    checkOutput("frame_hold_released", 32'(cpu_hold), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] last;

    rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Two-word frame with byte_valid held high.
    frame_words = '{16'h1234, 16'hABCD};
    load_frame(1'b0, 1'b0);

    // Empty frame: done follows the length bytes with no write.
    wr_q.delete();
    startLoad();
    applyStimulus(8'h00, 1'b0);
    checkOutput("n0_done_not_yet", 32'(done), 32'd0);
    applyStimulus(8'h00, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(8'h00, 1'b0);
`endif
    checkOutput("n0_done_next_cycle", 32'(done), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("n0_no_writes", 32'(wr_q.size()), 32'd0);

    tbl[0].n = 1; tbl[0].w = '0; tbl[0].w[0] = 16'hBEEF;
    tbl[0].exp_writes = 1; tbl[0].exp_last = 32'h0000_BEEF;
    tbl[1].n = 2; tbl[1].w = '0; tbl[1].w[0] = 16'h0001; tbl[1].w[1] = 16'hFFFF;
    tbl[1].exp_writes = 2; tbl[1].exp_last = 32'h0001_FFFF;
    tbl[2].n = 3; tbl[2].w[0] = 16'h00FF; tbl[2].w[1] = 16'hFF00; tbl[2].w[2] = 16'h8001;
    tbl[2].exp_writes = 3; tbl[2].exp_last = 32'h0002_8001;
    tbl[3].n = 0; tbl[3].w = '0;
    tbl[3].exp_writes = 0; tbl[3].exp_last = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      frame_words.delete();
      for (int i = 0; i < tbl[k].n; i++) frame_words.push_back(tbl[k].w[i]);
      load_frame(1'b1, 1'b0);
      last = (wr_q.size() > 0) ? wr_q[wr_q.size() - 1] : 32'hDEAD_BEEF;
      checkOutput("tbl_writes", 32'(wr_q.size()), 32'(tbl[k].exp_writes));
      checkOutput("tbl_last_write", last, tbl[k].exp_last);
    end

    // Randomised frames with byte_valid toggling.
    for (int r = 0; r < 8; r++) begin
      frame_words.delete();
      for (int i = 0; i < ((r < 4) ? 3 : int'($urandom_range(0, 5))); i++)
        frame_words.push_back(16'($urandom));
      load_frame(1'b1, 1'b0);
    end

    // Reset right after the first write of a two-word frame.
    wr_q.delete();
    startLoad();
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h5A, 1'b0);
    applyStimulus(8'h5A, 1'b0);
    checkOutput("abort_first_write", 32'(wr_enable), 32'd1);
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_zero_outputs("abort");
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort_one_write", 32'(wr_q.size()), 32'd1);
    frame_words = '{16'hC3C3, 16'h3C3C};
    load_frame(1'b0, 1'b0);

    // Start pulse while waiting for a low byte must be ignored.
    wr_q.delete();
    startLoad();
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h9C, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("mid_start_hold", 32'(cpu_hold), 32'd1);
    checkOutput("mid_start_ready", 32'(byte_ready), 32'd1);
    applyStimulus(8'h3E, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(8'h01 ^ 8'h9C ^ 8'h3E, 1'b0);
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("mid_start_writes", 32'(wr_q.size()), 32'd1);
    checkOutput("mid_start_word", (wr_q.size() > 0) ? wr_q[0] : 32'hDEAD_BEEF, 32'h0000_9C3E);
    checkOutput("mid_start_done", 32'(done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Trailer 0x27 is good for frame 00 01 12 34; 0x26 is bad.
    frame_words = '{16'h1234};
    load_frame(1'b0, 1'b0);
    load_frame(1'b0, 1'b1);
    frame_words = '{16'h1234};
    load_frame(1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
